// File: rtl/mine_map_gen.sv
// mine_map_gen: places NUM_MINES mines on a 64-cell map from a 16-bit LFSR,
// never on the latched safe cell, then pulses done and holds the map.
module mine_map_gen #(
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [5:0]  safe_pos,
  output logic [63:0] mines,
  output logic        busy,
  output logic        done,
  output logic        valid
);
  typedef enum logic [1:0] {S_IDLE, S_PLACE, S_DONE} state_t;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;
  state_t      state_q, state_d;
  logic [63:0] mines_q, mines_d;
  logic [5:0]  count_q, count_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  safe_q, safe_d;
  logic        valid_q, valid_d;
  logic [5:0]  cand;
  logic        start_ok, accept, last;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mines_q <= '0;
      count_q <= '0;
      lfsr_q  <= SEED_EFF;
      safe_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mines_q <= mines_d;
      count_q <= count_d;
      lfsr_q  <= lfsr_d;
      safe_q  <= safe_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    cand     = lfsr_q[5:0];
    start_ok = (state_q == S_IDLE) && start;
    accept   = (state_q == S_PLACE) && !mines_q[cand] && (cand != safe_q);
    last     = ({1'b0, count_q} + 7'd1) == 7'(NUM_MINES);
    state_d  = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_PLACE : S_IDLE;
      S_PLACE: state_d = (accept && last) ? S_DONE : S_PLACE;
      default: state_d = S_IDLE;
    endcase
    safe_d  = start_ok ? safe_pos : safe_q;
    mines_d = start_ok ? '0 : (mines_q | (accept ? (64'd1 << cand) : 64'd0));
    count_d = start_ok ? '0 : count_q + {5'd0, accept};
    // LFSR runs only while placing so each game continues the sequence
    lfsr_d  = (state_q == S_PLACE) ?
              {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
    valid_d = start_ok ? 1'b0 : ((state_q == S_DONE) ? 1'b1 : valid_q);
  end
  always_comb begin
    mines = mines_q;
    busy  = state_q != S_IDLE;
    done  = state_q == S_DONE;
    valid = valid_q || done;
  end
endmodule

// File: tb/tb_mine_map_gen.sv
// tb_mine_map_gen: three instances (1, 10, 63 mines) driven by directed and
// randomized games, checked against a draw-until-placed reference model.
module tb_mine_map_gen;
  localparam int NM [3] = '{1, 10, 63};
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start_v [3];
  logic [5:0]  safe_v [3];
  logic [63:0] mines_v [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        valid_v [3];
  logic [15:0] mlfsr [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mine_map_gen #(.NUM_MINES(1)) u0 (.clk(clk), .resetn(resetn), .start(start_v[0]), .safe_pos(safe_v[0]),
    .mines(mines_v[0]), .busy(busy_v[0]), .done(done_v[0]), .valid(valid_v[0]));
  mine_map_gen #(.NUM_MINES(10)) u1 (.clk(clk), .resetn(resetn), .start(start_v[1]), .safe_pos(safe_v[1]),
    .mines(mines_v[1]), .busy(busy_v[1]), .done(done_v[1]), .valid(valid_v[1]));
  mine_map_gen #(.NUM_MINES(63)) u2 (.clk(clk), .resetn(resetn), .start(start_v[2]), .safe_pos(safe_v[2]),
    .mines(mines_v[2]), .busy(busy_v[2]), .done(done_v[2]), .valid(valid_v[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_mines"}, mines_v[i], 64'd0);
      check({tag, "_busy"}, {63'd0, busy_v[i]}, 64'd0);
      check({tag, "_done"}, {63'd0, done_v[i]}, 64'd0);
      check({tag, "_valid"}, {63'd0, valid_v[i]}, 64'd0);
    end
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) mlfsr[i] = 16'hACE1;
  endtask

  // Model: draw lfsr[5:0] each placement cycle, keep it if free and not safe.
  task automatic play(input int i, input logic [5:0] sp, input bit hold, input bit pre,
                      output int lat, output logic [63:0] m);
    int n, cyc;
    logic [15:0] l;
    logic [5:0] c;
    m = '0; n = 0; cyc = 0; l = mlfsr[i];
    while (n < NM[i]) begin
      c = l[5:0];
      if (!m[c] && c != sp) begin m[c] = 1'b1; n++; end
      l = step(l);
      cyc++;
    end
    mlfsr[i] = l;
    if (!pre) begin
      @(negedge clk);
      safe_v[i] = sp;
      start_v[i] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) start_v[i] = 1'b0;
    check("busy_first", {63'd0, busy_v[i]}, 64'd1);
    check("valid_drop", {63'd0, valid_v[i]}, 64'd0);
    lat = 1;
    while (!done_v[i] && lat < 20000) begin
      safe_v[i] = 6'($urandom);
      @(negedge clk);
      lat++;
    end
    safe_v[i] = sp;
    check("latency", 64'(lat), 64'(cyc + 1));
    check("map", mines_v[i], m);
    check("valid_at_done", {63'd0, valid_v[i]}, 64'd1);
    check("busy_at_done", {63'd0, busy_v[i]}, 64'd1);
    @(negedge clk);
    check("done_once", {63'd0, done_v[i]}, 64'd0);
    check("busy_idle", {63'd0, busy_v[i]}, 64'd0);
    check("valid_hold", {63'd0, valid_v[i]}, 64'd1);
    check("map_stable", mines_v[i], m);
  endtask

  initial begin
    int lat;
    logic [63:0] m, prev;
    logic [5:0] sp;
    for (int i = 0; i < 3; i++) begin start_v[i] = 1'b0; safe_v[i] = '0; end
    do_reset();
    play(0, 6'd0, 0, 0, lat, m);
    check("n1_map_const", mines_v[0], 64'h1 << 33);
    check("n1_lat_const", 64'(lat), 64'd2);
    do_reset();
    play(0, 6'd33, 0, 0, lat, m);
    check("n1_safe_map_const", mines_v[0], 64'h8);
    check("n1_safe_lat_const", 64'(lat), 64'd3);
    prev = '1;
    for (int g = 0; g < 3; g++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      play(1, 6'd17, 0, 0, lat, m);
      check("n10_pop", 64'($countones(mines_v[1])), 64'd10);
      check("n10_safe_clear", {63'd0, mines_v[1][17]}, 64'd0);
      check("n10_differ", {63'd0, mines_v[1] != prev}, 64'd1);
      prev = mines_v[1];
    end
    sp = 6'($urandom);
    play(1, sp, 1, 0, lat, m);
    play(1, sp, 0, 1, lat, m);
    @(negedge clk);
    safe_v[1] = 6'd5;
    start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy", {63'd0, busy_v[1]}, 64'd1);
    do_reset();
    play(0, 6'd0, 0, 0, lat, m);
    check("post_reset_map", mines_v[0], 64'h1 << 33);
    play(2, 6'd63, 0, 0, lat, m);
    check("n63_map_const", mines_v[2], 64'h7FFF_FFFF_FFFF_FFFF);
    for (int g = 0; g < 4; g++) begin
      sp = 6'($urandom);
      play(1, sp, 0, 0, lat, m);
      check("rand_safe_clear", {63'd0, mines_v[1][sp]}, 64'd0);
      play(2, sp, 0, 0, lat, m);
      check("rand_n63_pop", 64'($countones(mines_v[2])), 64'd63);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
